// File: rtl/ex_hazard_ctrl_if.sv
// Execute-stage hazard controller interface: ID-stage instruction info and flush in,
// stall/bubble/forwarding controls and the stall counter out.
interface ex_hazard_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic             ex_bubble;
  logic [1:0]       forwd_mux1_ctrl;
  logic [1:0]       forwd_mux2_ctrl;
  logic [CNT_W-1:0] stall_count;

  // Pipeline side: drives the ID-stage view, consumes the controls.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_reg_write,
           id_mem_read, flush,
    input  stall, ex_bubble, forwd_mux1_ctrl, forwd_mux2_ctrl, stall_count
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_reg_write,
           id_mem_read, flush,
    output stall, ex_bubble, forwd_mux1_ctrl, forwd_mux2_ctrl, stall_count
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Hazard and forwarding controller for the execute stage of the 16-bit MIPS pipeline.
// Shadows EX/MEM/WB destination info, drives the ALU operand forwarding selects,
// inserts a one-cycle load-use stall and counts stall cycles (saturating).
module ex_hazard_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  ex_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rs;
    logic             uses_rt;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } mem_slot_t;

  // mem_read is dropped at WB: nothing downstream of MEM consults it.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             reg_write;
  } wb_slot_t;

  ex_slot_t   ex_q, ex_d;
  mem_slot_t  mem_q, mem_d;
  wb_slot_t   wb_q, wb_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic hz;
  logic stall;
  logic ex_bubble;
  logic [1:0] fwd1;
  logic [1:0] fwd2;

  // Select the youngest in-flight producer of src; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic ex_valid, input logic uses,
                                         input logic [REG_W-1:0] src,
                                         input mem_slot_t mem, input wb_slot_t wb);
    logic [1:0] sel;
    sel = FwdRf;
    if (ex_valid && uses && src != '0) begin
      if (mem.valid && mem.reg_write && mem.dest == src) begin
        sel = FwdMem;
      end else if (wb.valid && wb.reg_write && wb.dest == src) begin
        sel = FwdWb;
      end
    end
    return sel;
  endfunction

  // Load-use detection against the load sitting in EX; a flush makes the stall moot.
  always_comb begin
    hz = 1'b0;
    if (bus.id_valid && ex_q.valid && ex_q.mem_read && ex_q.dest != '0) begin
      hz = (bus.id_uses_rs && bus.id_rs == ex_q.dest) ||
           (bus.id_uses_rt && bus.id_rt == ex_q.dest);
    end
    stall     = hz && !bus.flush;
    ex_bubble = hz || bus.flush;
  end

  // Forwarding selects for the two ALU operands of the instruction in EX.
  always_comb begin
    fwd1 = fwd_sel(ex_q.valid, ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
    fwd2 = fwd_sel(ex_q.valid, ex_q.uses_rt, ex_q.rt, mem_q, wb_q);
  end

  // Next-state: shadows always shift; EX captures ID unless a bubble goes in.
  always_comb begin
    ex_d           = '0;
    ex_d.valid     = bus.id_valid && !ex_bubble;
    ex_d.rs        = bus.id_rs;
    ex_d.rt        = bus.id_rt;
    ex_d.uses_rs   = bus.id_uses_rs;
    ex_d.uses_rt   = bus.id_uses_rt;
    ex_d.dest      = bus.id_dest;
    ex_d.reg_write = bus.id_reg_write;
    ex_d.mem_read  = bus.id_mem_read;

    mem_d.valid     = ex_q.valid;
    mem_d.dest      = ex_q.dest;
    mem_d.reg_write = ex_q.reg_write;
    mem_d.mem_read  = ex_q.mem_read;

    wb_d.valid     = mem_q.valid;
    wb_d.dest      = mem_q.dest;
    wb_d.reg_write = mem_q.reg_write;

    stall_count_d = stall_count_q;
    if (stall && stall_count_q != '1) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Shadow registers and stall counter; reset discards all in-flight state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall           = stall;
  assign bus.ex_bubble       = ex_bubble;
  assign bus.forwd_mux1_ctrl = fwd1;
  assign bus.forwd_mux2_ctrl = fwd2;
  assign bus.stall_count     = stall_count_q;

  // A load in MEM never sources EX: the load-use stall always leaves a bubble between them.
  ex_no_mem_load_src: assert property (@(posedge clk) disable iff (rst)
    !(mem_q.valid && mem_q.mem_read && mem_q.dest != '0 && ex_q.valid &&
      ((ex_q.uses_rs && ex_q.rs == mem_q.dest) || (ex_q.uses_rt && ex_q.rt == mem_q.dest))));

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed vector table, hand-written reset and saturation
// sequences, then random instruction streams against a pipeline-level reference model.
module tb_ex_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } instr_t;

  typedef struct {
    instr_t ins;
    int     fl;
    int     st;
    int     bub;
    int     f1;
    int     f2;
    int     cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model: the instructions occupying EX, MEM, WB (index 0, 1, 2).
  instr_t m_pipe [3];
  int     m_c16;
  int     m_c2;

  ex_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();
  ex_hazard_ctrl_if #(.REG_W(5), .CNT_W(2))  bus_sat ();

  assign bus_sat.id_valid     = bus.id_valid;
  assign bus_sat.id_rs        = bus.id_rs;
  assign bus_sat.id_rt        = bus.id_rt;
  assign bus_sat.id_uses_rs   = bus.id_uses_rs;
  assign bus_sat.id_uses_rt   = bus.id_uses_rt;
  assign bus_sat.id_dest      = bus.id_dest;
  assign bus_sat.id_reg_write = bus.id_reg_write;
  assign bus_sat.id_mem_read  = bus.id_mem_read;
  assign bus_sat.flush        = bus.flush;

  ex_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ex_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mk(input int v, input int rs, input int rt, input int urs,
                                input int urt, input int dest, input int rw, input int mr);
    instr_t r;
    r.valid     = (v != 0);
    r.rs        = 5'(rs);
    r.rt        = 5'(rt);
    r.uses_rs   = (urs != 0);
    r.uses_rt   = (urt != 0);
    r.dest      = 5'(dest);
    r.reg_write = (rw != 0);
    r.mem_read  = (mr != 0);
    return r;
  endfunction

  function automatic vec_t mkv(input instr_t i, input int fl, input int st, input int bub,
                               input int f1, input int f2, input int cnt);
    vec_t v;
    v.ins = i; v.fl = fl; v.st = st; v.bub = bub; v.f1 = f1; v.f2 = f2; v.cnt = cnt;
    return v;
  endfunction

  // The instruction entering EX needs a value that the load now in EX only has after MEM.
  function automatic int m_hz(input instr_t id);
    instr_t ld;
    ld = m_pipe[0];
    if (!id.valid || !ld.valid || !ld.mem_read || ld.dest == 5'd0) return 0;
    if (id.uses_rs && id.rs == ld.dest) return 1;
    if (id.uses_rt && id.rt == ld.dest) return 1;
    return 0;
  endfunction

  // Walk older stages from youngest to oldest; first writer of src wins.
  function automatic int m_fwd(input logic uses, input logic [4:0] src);
    if (!m_pipe[0].valid || !uses || src == 5'd0) return 0;
    for (int s = 1; s <= 2; s++) begin
      if (m_pipe[s].valid && m_pipe[s].reg_write && m_pipe[s].dest == src)
        return (s == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) m_pipe[s] = '0;
    m_c16 = 0;
    m_c2  = 0;
  endtask

  task automatic model_adv(input instr_t id, input int fl);
    int hz;
    hz = m_hz(id);
    if (hz != 0 && fl == 0) begin
      if (m_c16 < 65535) m_c16++;
      if (m_c2 < 3) m_c2++;
    end
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = id;
    if (hz != 0 || fl != 0) m_pipe[0].valid = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input instr_t i, input int fl);
    bus.id_valid     = i.valid;
    bus.id_rs        = i.rs;
    bus.id_rt        = i.rt;
    bus.id_uses_rs   = i.uses_rs;
    bus.id_uses_rt   = i.uses_rt;
    bus.id_dest      = i.dest;
    bus.id_reg_write = i.reg_write;
    bus.id_mem_read  = i.mem_read;
    bus.flush        = (fl != 0);
  endtask

  task automatic chk_outs(input string tag, input int st, input int bub, input int f1,
                          input int f2, input int c16, input int c2);
    chk({tag, ".stall"}, 32'(bus.stall), st);
    chk({tag, ".ex_bubble"}, 32'(bus.ex_bubble), bub);
    chk({tag, ".fwd1"}, 32'(bus.forwd_mux1_ctrl), f1);
    chk({tag, ".fwd2"}, 32'(bus.forwd_mux2_ctrl), f2);
    chk({tag, ".count16"}, 32'(bus.stall_count), c16);
    chk({tag, ".count2"}, 32'(bus_sat.stall_count), c2);
  endtask

  // One pipeline cycle: present ID at negedge, check just after, advance model at posedge.
  task automatic step(input instr_t i, input int fl, input int st, input int bub,
                      input int f1, input int f2, input int c16, input int c2,
                      input string tag);
    @(negedge clk);
    drive(i, fl);
    #1;
    chk_outs(tag, st, bub, f1, f2, c16, c2);
    @(posedge clk);
    model_adv(i, fl);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic instr_t rnd_instr();
    instr_t r;
    r.valid     = ($urandom_range(0, 7) != 0);
    r.rs        = 5'($urandom_range(0, 5));
    r.rt        = 5'($urandom_range(0, 5));
    r.uses_rs   = ($urandom_range(0, 3) != 0);
    r.uses_rt   = ($urandom_range(0, 1) != 0);
    r.dest      = 5'($urandom_range(0, 5));
    r.mem_read  = ($urandom_range(0, 3) == 0);
    r.reg_write = r.mem_read || ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  vec_t tbl [18];

  initial begin
    instr_t cur;
    int     fl;
    int     hz;
    int     hold;

    // Forwarding distances, r0, MEM-over-WB priority, load-use stall, flush over hazard.
    tbl[0]  = mkv(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(mk(1, 8, 9, 1, 1, 10, 1, 0), 0, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(mk(1, 3, 6, 1, 1, 7, 1, 0), 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(mk(1, 7, 7, 1, 1, 12, 1, 0), 0, 0, 0, 1, 0, 0);
    tbl[4]  = mkv(mk(1, 0, 0, 1, 1, 0, 1, 0), 0, 0, 0, 2, 2, 0);
    tbl[5]  = mkv(mk(1, 0, 0, 1, 1, 0, 1, 0), 0, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0, 0, 0, 0, 0);
    tbl[7]  = mkv(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0, 0, 0, 0, 0);
    tbl[8]  = mkv(mk(1, 9, 5, 1, 1, 13, 1, 0), 0, 0, 0, 0, 0, 0);
    tbl[9]  = mkv(mk(1, 9, 9, 1, 1, 14, 1, 0), 0, 0, 0, 0, 2, 0);
    tbl[10] = mkv(mk(1, 1, 0, 1, 0, 4, 1, 1), 0, 0, 0, 0, 0, 0);
    tbl[11] = mkv(mk(1, 4, 2, 1, 1, 6, 1, 0), 0, 1, 1, 0, 0, 0);
    tbl[12] = mkv(mk(1, 4, 2, 1, 1, 6, 1, 0), 0, 0, 0, 0, 0, 1);
    tbl[13] = mkv(mk(1, 2, 2, 1, 1, 15, 1, 0), 0, 0, 0, 1, 0, 1);
    tbl[14] = mkv(mk(1, 1, 0, 1, 0, 4, 1, 1), 0, 0, 0, 0, 0, 1);
    tbl[15] = mkv(mk(1, 4, 2, 1, 1, 6, 1, 0), 1, 0, 1, 0, 0, 1);
    tbl[16] = mkv(mk(1, 4, 4, 1, 1, 16, 1, 0), 0, 0, 0, 0, 0, 1);
    tbl[17] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1, 1);

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
    model_reset();
    #2;
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].ins, tbl[i].fl, tbl[i].st, tbl[i].bub, tbl[i].f1, tbl[i].f2,
           tbl[i].cnt, (tbl[i].cnt > 3) ? 3 : tbl[i].cnt, $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle with a live stall and a MEM forward in flight.
    do_reset();
    step(mk(1, 1, 2, 1, 1, 3, 1, 0), 0, 0, 0, 0, 0, 0, 0, "mid.add");
    step(mk(1, 3, 0, 1, 0, 4, 1, 1), 0, 0, 0, 0, 0, 0, 0, "mid.lw");
    @(negedge clk);
    drive(mk(1, 4, 2, 1, 1, 6, 1, 0), 0);
    #1;
    chk_outs("mid.pre", 1, 1, 2, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_outs("mid.rst", 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);

    // Four back-to-back load-use stalls: the 2-bit counter reads 1,2,3,3.
    do_reset();
    step(mk(1, 1, 0, 1, 0, 4, 1, 1), 0, 0, 0, 0, 0, 0, 0, "sat.lw0");
    for (int k = 1; k <= 4; k++) begin
      step(mk(1, 4, 0, 1, 0, 4, 1, 1), 0, 1, 1, (k == 1) ? 0 : 1, 0, k - 1,
           (k - 1 > 3) ? 3 : k - 1, $sformatf("sat.stall%0d", k));
      step(mk(1, 4, 0, 1, 0, 4, 1, 1), 0, 0, 0, 0, 0, k, (k > 3) ? 3 : k,
           $sformatf("sat.held%0d", k));
    end

    // Random streams; a stalled ID instruction is re-presented the next cycle.
    do_reset();
    hold = 0;
    cur  = '0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) cur = rnd_instr();
      fl = ($urandom_range(0, 9) == 0) ? 1 : 0;
      hz = m_hz(cur);
      step(cur, fl, (hz != 0 && fl == 0) ? 1 : 0, (hz != 0 || fl != 0) ? 1 : 0,
           m_fwd(m_pipe[0].uses_rs, m_pipe[0].rs), m_fwd(m_pipe[0].uses_rt, m_pipe[0].rt),
           m_c16, m_c2, $sformatf("rnd%0d", i));
      hold = (hz != 0 && fl == 0) ? 1 : 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Hazard and forwarding controller for the execute stage of the 16-bit MIPS pipeline.
- Shadows the destination and write-enable information of the instructions in EX, MEM and WB.
- Drives the two execute-stage forwarding mux selects (ALU input 1 and input 2 operand paths).
- Detects load-use hazards and stalls IF/ID while inserting a bubble into EX.
- Honours branch flushes and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 16, stall counter width

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_W  ID source register 1 (feeds ALU input 1)
id_rt  input  REG_W  ID source register 2 (feeds ALU input 2 / store data)
id_uses_rs  input  1  instruction reads rs
id_uses_rt  input  1  instruction reads rt
id_dest  input  REG_W  resolved destination register (after reg_dest mux selection)
id_reg_write  input  1  instruction writes the register file
id_mem_read  input  1  instruction is a load
flush  input  1  branch taken, resolved in EX; kill the ID instruction
stall  output  1  hold PC and IF/ID register (combinational)
ex_bubble  output  1  EX pipeline register loads a NOP this cycle (combinational)
forwd_mux1_ctrl  output  2  forwarding select for ALU input 1
forwd_mux2_ctrl  output  2  forwarding select for ALU input 2
stall_count  output  CNT_W  saturating count of load-use stall cycles

Behaviour:
Reset:
- Asynchronous and active-high; reset is one clock, no synchronizer in this block.
- Clears all shadow valid bits and stall_count.
- With all valids clear: stall=0, ex_bubble=0, both fwd selects=00.
- Reset mid-operation discards all in-flight shadow state.

Shadow registers:
- One shadow slot each for EX, MEM and WB.
- EX slot holds {valid, rs, rt, uses_rs, uses_rt, dest, reg_write, mem_read}.
- MEM and WB slots hold {valid, dest, reg_write, mem_read}.
- Every cycle: WB <= MEM, MEM <= EX; this shift is never gated.
- EX <= ID fields with valid = id_valid, unless ex_bubble is asserted, in which case EX.valid <= 0.

Load-use detection (combinational):
- hz = id_valid & EX.valid & EX.mem_read & (EX.dest != 0) & ((id_uses_rs & id_rs == EX.dest) | (id_uses_rt & id_rt == EX.dest)).
- stall = hz & ~flush.
- ex_bubble = stall | flush.
- Flush takes priority: the ID instruction is discarded, so no stall is needed.
- A stall lasts exactly 1 cycle. Next cycle the load is in MEM, the EX slot holds the bubble, and hz evaluates 0.

Forwarding (combinational from EX/MEM/WB shadows, for the instruction currently in EX):
- Mux encoding: 00 = register-file operand, 01 = wb_w_data (WB stage), 10 = mem_alu_out (MEM stage), 11 = unused and never driven.
- forwd_mux1_ctrl = 10 if EX.valid & EX.uses_rs & MEM.valid & MEM.reg_write & MEM.dest != 0 & MEM.dest == EX.rs.
- Otherwise 01 if the same condition holds with WB in place of MEM.
- Otherwise 00.
- forwd_mux2_ctrl is identical, using EX.rt and EX.uses_rt.
- MEM has priority over WB because it is the younger producer.
- Register 0 is never forwarded.
- A MEM-stage load matching an EX source is impossible by construction because of the stall. The verification engineer asserts this property.
- Same-cycle register-file write/read in ID is handled by the register file itself, not here.

Stall counter:
- stall_count increments on each clock edge where stall=1.
- Saturates at 2^CNT_W-1; no wrap.

Simultaneous events:
- flush and hz together: no stall, bubble inserted, counter unchanged.
- flush does not affect MEM or WB; older instructions complete.

Test Plan:
- Reset → all outputs 0; assert rst mid-stream with valid shadows → fwd selects 00 and stall 0 immediately (asynchronous reset).
- ADD r3 then SUB rs=r3 back-to-back → in SUB's EX cycle forwd_mux1_ctrl=10; with one independent instruction between them → 01; with rs=r3 and rt=r3 → both selects 10.
- Producers to r5 in both MEM and WB, EX reads rt=r5 → forwd_mux2_ctrl=10 (MEM priority); r0 as destination and source → 00.
- LW r4 then ADD rs=r4 → stall=1 and ex_bubble=1 for exactly 1 cycle, stall_count 0→1; ADD then sees forwd_mux1_ctrl=01.
- LW r4 followed by dependent ADD with flush=1 in the same cycle → stall=0, ex_bubble=1, stall_count unchanged, next-cycle fwd selects 00.
- CNT_W=2, four consecutive load-use stalls → stall_count reads 1,2,3,3 (saturates, no wrap).
